voice_scheduler: RTL

//  Sits between song_reader and a bank of NUM_VOICES note players.
//  - Buffers each note/duration pair that song_reader emits.
//  - Sends the oldest buffered note to the lowest-index idle voice.
//  - Times each voice's note in beats and frees the voice when the note ends.
//  - Drives song_reader's player_available handshake.
//  - Reports end of song once song_reader is done and all voices have drained.

---
 rtl/voice_scheduler_if.sv | 27 ++
 rtl/voice_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/voice_scheduler_if.sv
// Song-reader and voice-bank signals of the voice scheduler.
// The master side feeds notes in and watches the voices; the scheduler is the slave.
interface voice_scheduler_if #(
   parameter int unsigned NUM_VOICES = 3,
   parameter int unsigned NOTE_W     = 6,
   parameter int unsigned DUR_W      = 6
);
   logic                         new_note;
   logic [NOTE_W-1:0]            note;
   logic [DUR_W-1:0]             duration;
   logic                         song_done;
   logic                         player_available;
   logic [NUM_VOICES-1:0]        voice_load;
   logic [NUM_VOICES*NOTE_W-1:0] voice_note;
   logic [NUM_VOICES-1:0]        voice_busy;
   logic                         all_done;

   modport master (
      output new_note, note, duration, song_done,
      input  player_available, voice_load, voice_note, voice_busy, all_done
   );

   modport slave (
      input  new_note, note, duration, song_done,
      output player_available, voice_load, voice_note, voice_busy, all_done
   );
endinterface

// File: rtl/voice_scheduler.sv
// Buffers note/duration pairs, hands the oldest to the lowest idle voice and
// times each voice in beats; flags end of song once everything has drained.
module voice_scheduler #(
   parameter int unsigned NUM_VOICES = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned NOTE_W     = 6,
   parameter int unsigned DUR_W      = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              stop,
   input  logic              beat,
   voice_scheduler_if.slave  bus
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   logic [NOTE_W-1:0]            fifo_note [FIFO_DEPTH];
   logic [DUR_W-1:0]             fifo_dur  [FIFO_DEPTH];
   logic [PTR_W-1:0]             wr_ptr, rd_ptr;
   logic [CNT_W-1:0]             count;
   logic                         run, fifo_full, fifo_empty;
   logic                         push, pop, dispatch, any_idle;
   logic [VIDX_W-1:0]            target;
   logic [NUM_VOICES-1:0]        busy, busy_nxt;
   logic [DUR_W-1:0]             remaining [NUM_VOICES];
   logic [DUR_W-1:0]             rem_nxt   [NUM_VOICES];
   logic [NUM_VOICES-1:0]        load, load_nxt;
   logic [NUM_VOICES*NOTE_W-1:0] notes, notes_nxt;
   logic                         done_latch, all_done;

   assign run        = play & ~stop;
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);

   assign bus.player_available = reset & run & ~fifo_full;
   assign push     = bus.new_note & bus.player_available;
   assign pop      = run & ~fifo_empty & any_idle;
   // Zero-length entries are popped but never occupy a voice
   assign dispatch = pop & (fifo_dur[rd_ptr] != '0);

   // Lowest-index idle voice
   always_comb begin
      any_idle = 1'b0;
      target   = '0;
      for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            any_idle = 1'b1;
            target   = VIDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_note[wr_ptr] <= bus.note;
         fifo_dur[wr_ptr]  <= bus.duration;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (stop) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Voice timer state register (busy = BUSY state)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy      <= '0;
         remaining <= '{default: '0};
      end else begin
         busy      <= busy_nxt;
         remaining <= rem_nxt;
      end
   end

   // Voice timer next state; a freshly loaded voice was idle, so it skips this beat
   always_comb begin
      busy_nxt = busy;
      rem_nxt  = remaining;
      if (stop) begin
         busy_nxt = '0;
         rem_nxt  = '{default: '0};
      end else if (play) begin
         for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (busy[i] && beat) begin
               rem_nxt[i] = remaining[i] - DUR_W'(1);
               if (remaining[i] == DUR_W'(1)) busy_nxt[i] = 1'b0;
            end
         end
         if (dispatch) begin
            busy_nxt[target] = 1'b1;
            rem_nxt[target]  = fifo_dur[rd_ptr];
         end
      end
   end

   // Voice outputs: idle voices show note 0
   always_comb begin
      load_nxt  = '0;
      notes_nxt = notes;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
         if (!busy_nxt[i]) notes_nxt[i*NOTE_W +: NOTE_W] = '0;
      end
      if (dispatch) begin
         load_nxt[target]                       = 1'b1;
         notes_nxt[target*NOTE_W +: NOTE_W]     = fifo_note[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load       <= '0;
         notes      <= '0;
         done_latch <= 1'b0;
         all_done   <= 1'b0;
      end else begin
         load  <= load_nxt;
         notes <= notes_nxt;
         if (stop) begin
            done_latch <= 1'b0;
            all_done   <= 1'b0;
         end else if (play) begin
            if (bus.song_done) done_latch <= 1'b1;
            all_done <= done_latch & fifo_empty & ~|busy;
         end
      end
   end

   assign bus.voice_load = load;
   assign bus.voice_note = notes;
   assign bus.voice_busy = busy;
   assign bus.all_done   = all_done;

   always @(posedge clk) begin
      if (reset) begin
         assert ((load_nxt & busy) == '0);
         assert ($onehot0(load_nxt));
         assert (!(push && fifo_full));
      end
   end

endmodule
